// File: rtl/bet_scanner.sv
// Purpose : scans six 8:1 switch banks (38 bet positions) through a shared mux
//           address, debounces whole-scan results and hands one bet at a time
//           to the processor with a valid/ack handshake.
// Latency : a key held from scan start is reported on the cycle after its
//           DEBOUNCE_SCANS-th completed scan (8*SETTLE_CYCLES cycles per scan).
// Backpr. : a pending bet is held until bet_ack. Presses debounced meanwhile
//           are dropped, and a key must be released before the next report.
// Ports   : clock/reset (async active-low). scan_select is the mux address.
//           bank_sense is the raw, asynchronous bank returns.
//           bet_number/bet_valid/bet_ack form the report handshake.
//           multi_press flags a scan that saw more than one press.
module bet_scanner #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    output logic [2:0] scan_select,
    input  logic [5:0] bank_sense,
    output logic [5:0] bet_number,
    output logic       bet_valid,
    input  logic       bet_ack,
    output logic       multi_press
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_FULL   = SW'(DEBOUNCE_SCANS);
    localparam logic [5:0]    LAST_POS    = 6'd37;

    typedef enum logic [1:0] {CLS_EMPTY, CLS_SINGLE, CLS_MULTI} cls_e;
    typedef enum logic [1:0] {ST_ARMED, ST_PENDING, ST_WAIT_RELEASE} state_e;

    // synchronizer
    logic [5:0]    sync1_q, sync2_q;
    // scan timing
    logic [CW-1:0] settle_q;
    logic [2:0]    sel_q;
    // per-scan accumulation: count saturates at 2 (= "more than one")
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic [5:0]    acc_pos_q, acc_pos_d;
    // debounce history
    cls_e          hist_cls_q;
    logic [5:0]    hist_pos_q;
    logic [SW-1:0] stab_q, stab_d;
    // report side
    state_e        state_q;
    logic [5:0]    bet_number_q;
    logic          bet_valid_q;
    logic          multi_q;

    logic          sample_now, scan_done, stable;
    logic [2:0]    hits;
    logic [5:0]    hit_pos, cand_pos, scan_pos;
    logic [3:0]    cnt_sum;
    cls_e          scan_cls;

    assign sample_now = (settle_q == SETTLE_LAST);
    assign scan_done  = sample_now && (sel_q == 3'd7);

    // Presses seen on the current mux address; positions 38..47 are ignored.
    always_comb begin
        hits     = 3'd0;
        hit_pos  = 6'd0;
        cand_pos = 6'd0;
        for (int b = 0; b < 6; b++) begin
            cand_pos = {3'(b), sel_q};
            if (sync2_q[b] && (cand_pos <= LAST_POS)) begin
                if (hits == 3'd0) begin
                    hit_pos = cand_pos;
                end
                hits = hits + 3'd1;
            end
        end
    end

    // Fold this sample into the running scan result. The final class of a
    // scan is taken from these next-state values on the sel=7 sample.
    always_comb begin
        cnt_sum   = {2'b00, acc_cnt_q} + {1'b0, hits};
        acc_cnt_d = (cnt_sum >= 4'd2) ? 2'd2 : cnt_sum[1:0];
        acc_pos_d = ((acc_cnt_q == 2'd0) && (hits != 3'd0)) ? hit_pos : acc_pos_q;
        case (acc_cnt_d)
            2'd0:    scan_cls = CLS_EMPTY;
            2'd1:    scan_cls = CLS_SINGLE;
            default: scan_cls = CLS_MULTI;
        endcase
        // position only distinguishes SINGLE results
        scan_pos = (scan_cls == CLS_SINGLE) ? acc_pos_d : 6'd0;
    end

    // Stability count for the scan completing now.
    always_comb begin
        if ((scan_cls == CLS_SINGLE || scan_cls == CLS_EMPTY || scan_cls == CLS_MULTI)
            && (scan_cls == hist_cls_q) && (scan_pos == hist_pos_q)) begin
            stab_d = (stab_q == STAB_FULL) ? stab_q : stab_q + SW'(1);
        end else begin
            stab_d = SW'(1);
        end
        stable = (stab_d == STAB_FULL);
    end

    // Synchronizer, scan timing, accumulation and debounce history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 6'd0;
            sync2_q    <= 6'd0;
            settle_q   <= '0;
            sel_q      <= 3'd0;
            acc_cnt_q  <= 2'd0;
            acc_pos_q  <= 6'd0;
            hist_cls_q <= CLS_EMPTY;
            hist_pos_q <= 6'd0;
            stab_q     <= '0;
            multi_q    <= 1'b0;
        end else begin
            sync1_q <= bank_sense;
            sync2_q <= sync1_q;
            if (sample_now) begin
                settle_q <= '0;
                sel_q    <= sel_q + 3'd1;   // 7 wraps to 0
                if (scan_done) begin
                    acc_cnt_q  <= 2'd0;
                    acc_pos_q  <= 6'd0;
                    hist_cls_q <= scan_cls;
                    hist_pos_q <= scan_pos;
                    stab_q     <= stab_d;
                    multi_q    <= (scan_cls == CLS_MULTI);
                end else begin
                    acc_cnt_q <= acc_cnt_d;
                    acc_pos_q <= acc_pos_d;
                end
            end else begin
                settle_q <= settle_q + CW'(1);
            end
        end
    end

    // Report FSM with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_ARMED;
            bet_number_q <= 6'd0;
            bet_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (scan_done && (scan_cls == CLS_SINGLE) && stable) begin
                        bet_number_q <= scan_pos;
                        bet_valid_q  <= 1'b1;
                        state_q      <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (bet_ack) begin
                        bet_valid_q <= 1'b0;
                        state_q     <= ST_WAIT_RELEASE;
                    end
                end
                ST_WAIT_RELEASE: begin
                    // MULTI scans never count as released.
                    if (scan_done && (scan_cls == CLS_EMPTY) && stable) begin
                        state_q <= ST_ARMED;
                    end
                end
                default: begin
                    state_q     <= ST_ARMED;
                    bet_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign scan_select = sel_q;
    assign bet_number  = bet_number_q;
    assign bet_valid   = bet_valid_q;
    assign multi_press = multi_q;

endmodule

// File: tb/tb_bet_scanner.sv
// Purpose : self-checking bench for bet_scanner; a switch-matrix model drives
//           bank_sense from scan_select, and a scan-level reference predicts
//           every handshake output.
// Latency : checks land one time unit after the edge under test.
// Backpr. : acks are placed at random points in a scan, including while idle.
module tb_bet_scanner;

    localparam int SET  = 16;
    localparam int SCAN = 8 * SET;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] scan_select;
    logic [5:0] bank_sense;
    logic [5:0] bet_number;
    logic       bet_valid;
    logic       bet_ack;
    logic       multi_press;

    logic [47:0] keys;

    int n_cmp = 0;
    int n_err = 0;

    // reference state: history of scan signatures (-1 empty, -2 multi, p single)
    int   hist[$];
    int   mode;          // 0 armed, 1 reported/awaiting ack, 2 awaiting release
    logic exp_valid;
    int   exp_num;
    logic exp_multi;

    bet_scanner #(.SETTLE_CYCLES(SET), .DEBOUNCE_SCANS(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .scan_select (scan_select),
        .bank_sense  (bank_sense),
        .bet_number  (bet_number),
        .bet_valid   (bet_valid),
        .bet_ack     (bet_ack),
        .multi_press (multi_press)
    );

    always #5 clock = ~clock;

    // switch matrix: bank b returns the switch at position 8*b + select
    always_comb begin
        bank_sense = 6'd0;
        for (int b = 0; b < 6; b++) begin
            bank_sense[b] = keys[8 * b + int'(scan_select)];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] key(input int p);
        logic [47:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic int classify(input logic [47:0] k);
        int n, p;
        n = 0;
        p = 0;
        for (int i = 0; i <= 37; i++) begin
            if (k[i]) begin
                n++;
                p = i;
            end
        end
        if (n == 0) return -1;
        if (n > 1)  return -2;
        return p;
    endfunction

    task automatic model_reset();
        hist.delete();
        mode      = 0;
        exp_valid = 1'b0;
        exp_num   = 0;
        exp_multi = 1'b0;
    endtask

    task automatic model_scan(input logic [47:0] k);
        int  sig;
        bit  steady;
        sig = classify(k);
        hist.push_back(sig);
        if (hist.size() > 4) void'(hist.pop_front());
        steady = (hist.size() == 4);
        foreach (hist[i]) if (hist[i] != sig) steady = 0;
        exp_multi = (sig == -2);
        if (mode == 0 && sig >= 0 && steady) begin
            exp_valid = 1'b1;
            exp_num   = sig;
            mode      = 1;
        end else if (mode == 2 && sig == -1 && steady) begin
            mode = 0;
        end
    endtask

    task automatic model_ack();
        if (mode == 1) begin
            mode      = 2;
            exp_valid = 1'b0;
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".vld"},   32'(bet_valid),   32'(exp_valid));
        check({tag, ".num"},   32'(bet_number),  32'(exp_num));
        check({tag, ".multi"}, 32'(multi_press), 32'(exp_multi));
    endtask

    // One full scan with keys k held; optional one-cycle ack after edge ack_at.
    task automatic do_scan(input logic [47:0] k, input int ack_at);
        keys = k;
        for (int j = 1; j <= SCAN; j++) begin
            @(posedge clock);
            #1;
            if (ack_at > 0 && j == ack_at + 1) begin
                bet_ack = 1'b0;
                model_ack();
                check("ack.vld", 32'(bet_valid), 32'(exp_valid));
            end
            if (j == SCAN) model_scan(k);
            if (ack_at > 0 && j == ack_at) bet_ack = 1'b1;
            if (j % SET == 0) begin
                check("sel", 32'(scan_select), 32'((j / SET) % 8));
                check_outs("scan");
            end
        end
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        bet_ack = 1'b0;
        #1;
        model_reset();
        check("rst.sel",   32'(scan_select), 32'd0);
        check_outs("rst");
        repeat (3) @(posedge clock);
        #1;
        check("rsth.sel",  32'(scan_select), 32'd0);
        check("rsth.vld",  32'(bet_valid),   32'd0);
        reset = 1'b1;
    endtask

    task automatic scans(input logic [47:0] k, input int n);
        for (int i = 0; i < n; i++) do_scan(k, 0);
    endtask

    initial begin
        logic [47:0] pat;
        int          hold, ack_at;
        keys    = '0;
        bet_ack = 1'b0;
        reset   = 1'b0;
        model_reset();
        #2;
        do_reset();

        // idle scanning
        scans('0, 2);

        // 17 held: report after the 4th scan, ack, held 10 scans, release, then 5
        scans(key(17), 4);
        check("rpt17.vld", 32'(bet_valid), 32'd1);
        check("rpt17.num", 32'(bet_number), 32'd17);
        do_scan(key(17), 20);
        scans(key(17), 9);
        check("hold17.vld", 32'(bet_valid), 32'd0);
        check("hold17.num", 32'(bet_number), 32'd17);
        scans('0, 4);
        scans(key(5), 4);
        check("rpt5.num", 32'(bet_number), 32'd5);
        do_scan(key(5), 50);
        scans('0, 4);

        // 9 bouncing, then held
        do_scan(key(9), 0);
        do_scan('0, 0);
        scans(key(9), 3);
        check("bounce9.vld", 32'(bet_valid), 32'd0);
        do_scan(key(9), 0);
        check("rpt9.num", 32'(bet_number), 32'd9);
        do_scan(key(9), 7);
        scans('0, 4);

        // 3 and 20 together, then 20 released
        scans(key(3) | key(20), 4);
        check("multi.flag", 32'(multi_press), 32'd1);
        scans(key(3), 4);
        check("rpt3.num",   32'(bet_number), 32'd3);
        check("rpt3.multi", 32'(multi_press), 32'd0);
        do_scan(key(3), 90);
        scans('0, 4);

        // out-of-range 40, then 12 added
        scans(key(40), 4);
        check("pos40.vld", 32'(bet_valid), 32'd0);
        scans(key(40) | key(12), 4);
        check("rpt12.num", 32'(bet_number), 32'd12);
        do_scan(key(40) | key(12), 33);
        scans('0, 4);

        // 22 reported, reset while pending, reported again
        scans(key(22), 4);
        check("rpt22.vld", 32'(bet_valid), 32'd1);
        repeat (37) @(posedge clock);
        #1;
        do_reset();
        scans(key(22), 4);
        check("rpt22b.num", 32'(bet_number), 32'd22);
        do_scan(key(22), 11);
        scans('0, 4);

        // randomized patterns held for random runs, with random acks
        pat = '0;
        for (int r = 0; r < 16; r++) begin
            case ($urandom_range(0, 4))
                0:       pat = '0;
                1:       pat = key($urandom_range(0, 47));
                2:       pat = key($urandom_range(0, 47)) | key($urandom_range(0, 47));
                default: pat = key($urandom_range(0, 37));
            endcase
            hold = $urandom_range(1, 6);
            for (int h = 0; h < hold; h++) begin
                ack_at = ($urandom_range(0, 2) != 0) ? $urandom_range(1, 100) : 0;
                do_scan(pat, ack_at);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bet_scanner.md
BET_SCANNER -- requirements
Module: bet_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, 16, clock cycles each mux address is held before sampling (>=4).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, 4, consecutive identical full-scan results needed to accept a change (>=2).
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port scan_select  output  3  mux address shared by all six external 8:1 switch banks.
REQ-006 SHALL have port bank_sense  input  6  return line of bank b; high means the selected switch is pressed; asynchronous to clock.
REQ-007 SHALL have port bet_number  output  6  accepted bet position, 0..37 (37 = "00").
REQ-008 SHALL have port bet_valid  output  1  bet_number holds a new unacknowledged bet.
REQ-009 SHALL have port bet_ack  input  1  processor consumed bet_number.
REQ-010 SHALL have port multi_press  output  1  last completed scan saw more than one in-range press.

Function
REQ-011 SHALL pass bank_sense through a 2-flop synchronizer before any use.
REQ-012 SHALL map position p = 8*bank + scan_select, matching the LED mux encoding (bank p/8, select p%8).
REQ-013 SHALL hold each scan_select value SETTLE_CYCLES cycles, sample the synchronized bank_sense on the last cycle, then advance; 7 wraps to 0.
REQ-014 SHALL complete one full scan every 8*SETTLE_CYCLES cycles (128 at defaults), ending with the sample at scan_select=7.
REQ-015 SHALL ignore positions 38..47 entirely (not counted as presses).
REQ-016 SHALL classify each completed scan as EMPTY (0 in-range presses), SINGLE(p) (exactly 1), or MULTI (>1).
REQ-017 SHALL update multi_press on the cycle after scan completion: 1 if MULTI, else 0.
REQ-018 SHALL keep a stability count: increment (saturating at DEBOUNCE_SCANS) if the class and p equal the previous scan's, else reset to 1.
REQ-019 SHALL implement report FSM states ARMED, PENDING, WAIT_RELEASE.
REQ-020 ARMED -> PENDING when a scan completes with SINGLE(p) and stability count reaching DEBOUNCE_SCANS; on the next cycle bet_number=p, bet_valid=1.
REQ-021 PENDING: bet_valid held 1 and bet_number stable until bet_ack sampled high; bet_valid=0 on the following cycle; -> WAIT_RELEASE.
REQ-022 WAIT_RELEASE -> ARMED when a scan completes EMPTY with stability count reaching DEBOUNCE_SCANS; a held key SHALL never be reported twice.
REQ-023 SHALL ignore bet_ack while bet_valid=0.
REQ-024 SHALL discard presses debounced while in PENDING or WAIT_RELEASE (no queueing).
REQ-025 MULTI scans SHALL never produce a report and count as non-empty for release.
REQ-026 bet_number SHALL retain its last value after acknowledgment until the next report.
REQ-027 Scanning SHALL run continuously regardless of FSM state.

Reset
REQ-028 While reset=0: scan_select=0, bet_number=0, bet_valid=0, multi_press=0, synchronizers=0, all counters=0, stability history=EMPTY with count 0, FSM=ARMED; asynchronous, effective without a clock edge.
REQ-029 After reset release, first settle period SHALL begin at scan_select=0 on the next rising edge.
REQ-030 Reset mid-PENDING SHALL drop bet_valid immediately and discard the pending bet.

Verification
REQ-031 Reset, no presses -> all outputs 0; scan_select steps 0..7 with 16 cycles per step, 128-cycle period, bet_valid never asserts.
REQ-032 Hold position 17 (bank 2, select 1) from scan start -> after 4th scan bet_valid=1, bet_number=17; one-cycle bet_ack -> bet_valid=0 next cycle; key kept held 10 scans -> no re-report; release 4 scans, press 5 -> bet_number=5, bet_valid=1.
REQ-033 Position 9 alternating pressed/released on successive scans for 3 scans then held -> bet_valid only after 4 consecutive pressed scans, bet_number=9.
REQ-034 Positions 3 and 20 held together -> multi_press=1 after each scan, bet_valid stays 0; release 20 -> report 3 after 4 scans, multi_press=0.
REQ-035 Position 40 held alone -> no report, multi_press=0; add position 12 -> bet_number=12 after 4 scans.
REQ-036 Report 22, withhold ack, assert reset mid-PENDING -> bet_valid=0 asynchronously, bet_number=0, scan_select=0; after release a still-held 22 is reported again after 4 scans.
